// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and constants for the pipelined immediate decoder
package imm_pkg;

    localparam int INSTR_W = 32;
    localparam int SEL_W   = 3;

    typedef enum logic [SEL_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_U = 3'd2,
        IMM_Z = 3'd3,
        IMM_J = 3'd4,
        IMM_B = 3'd5
    } imm_sel_e;

endpackage

// File: rtl/imm_dec_pipe_if.sv
// rtl/imm_dec_pipe_if.sv - instruction-in / immediate-out handshake bundle
interface imm_dec_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) ();

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [SEL_W-1:0]   in_sel;
    logic [TAG_W-1:0]   in_tag;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_imm;
    logic [TAG_W-1:0]   out_tag;
    logic               out_err;

    modport slave (
        input  in_valid, in_instr, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport master (
        output in_valid, in_instr, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

endinterface

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational immediate extraction for all formats
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [XLEN-1:0]    imm_o,
    output logic               err_o
);

    logic [63:0] imm_full;
    logic        s;
    logic        unused_sink;

    assign s = instr_i[31];

    // Every format is built at 64 bits and truncated, so XLEN=32 needs no special case.
    always_comb begin
        imm_full = 64'd0;
        err_o    = 1'b0;
        case (imm_sel_e'(sel_i))
            IMM_I:   imm_full = {{52{s}}, instr_i[31:20]};
            IMM_S:   imm_full = {{52{s}}, instr_i[31:25], instr_i[11:7]};
            IMM_U:   imm_full = {{32{s}}, instr_i[31:12], 12'h000};
            IMM_Z:   imm_full = {59'd0, instr_i[19:15]};
            IMM_J:   imm_full = {{44{s}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            IMM_B:   imm_full = {{52{s}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            default: err_o    = 1'b1;
        endcase
    end

    assign imm_o       = imm_full[XLEN-1:0];
    assign unused_sink = ^{instr_i[6:0], imm_full};

endmodule

// File: rtl/imm_dec_pipe.sv
// rtl/imm_dec_pipe.sv - registered immediate decoder with one-entry skid buffer
module imm_dec_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    imm_dec_pipe_if.slave  bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_bad
        $error("imm_dec_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             err;
        logic [TAG_W-1:0] tag;
    } imm_entry_t;

    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    imm_entry_t      in_entry;

    imm_entry_t out_q, out_d;
    imm_entry_t skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       accept;
    logic       deliver;

    imm_ext_core #(.XLEN(XLEN)) u_core (
        .instr_i (bus.in_instr),
        .sel_i   (bus.in_sel),
        .imm_o   (dec_imm),
        .err_o   (dec_err)
    );

    assign in_entry = '{imm: dec_imm, err: dec_err, tag: bus.in_tag};
    assign accept   = bus.in_valid && !skid_valid_q;
    assign deliver  = out_valid_q && bus.out_ready;

    // A full skid forces in_ready low, so fill and drain of the skid never coincide.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || deliver) begin
            skid_valid_d = 1'b0;
            if (skid_valid_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = in_entry;
                end
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_q.imm;
    assign bus.out_err   = out_q.err;
    assign bus.out_tag   = out_q.tag;

endmodule

// File: tb/tb_imm_dec_pipe.sv
// tb/tb_imm_dec_pipe.sv - bench for imm_dec_pipe at XLEN 32 and 64
module tb_imm_dec_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    imm_dec_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
    imm_dec_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

    imm_dec_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(bus32.slave));
    imm_dec_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64.slave));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0] imm;
        logic        err;
        logic [31:0] tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    logic [31:0] t_ins [7] = '{32'hFFF00093, 32'hFE512E23, 32'hFE000CE3, 32'h123450B7,
                               32'h800000B7, 32'h000FD073, 32'h00000000};
    logic [2:0]  t_sel [7] = '{3'd0, 3'd1, 3'd5, 3'd2, 3'd2, 3'd3, 3'd6};
    logic [63:0] t_exp [7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                               64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h000000000000001F,
                               64'h0};
    logic        t_err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [63:0] sxt(input longint v, input int bits);
        longint r;
        r = v;
        if (r >= (longint'(1) <<< (bits - 1))) r = r - (longint'(1) <<< bits);
        return r;
    endfunction

    // Immediate value from the ISA field layouts, using plain arithmetic on the word.
    function automatic logic [64:0] ref_dec(input logic [31:0] ins, input logic [2:0] sel, input int xlen);
        longint      u;
        logic [63:0] v;
        logic        e;
        u = longint'(ins);
        e = 1'b0;
        case (sel)
            3'd0: v = sxt(u >> 20, 12);
            3'd1: v = sxt(((u >> 25) << 5) + ((u >> 7) & 31), 12);
            3'd2: v = sxt(u & 64'hFFFFF000, 32);
            3'd3: v = (u >> 15) & 31;
            3'd4: v = sxt((((u >> 31) & 1) << 20) + (((u >> 12) & 255) << 12)
                          + (((u >> 20) & 1) << 11) + (((u >> 21) & 1023) << 1), 21);
            3'd5: v = sxt((((u >> 31) & 1) << 12) + (((u >> 7) & 1) << 11)
                          + (((u >> 25) & 63) << 5) + (((u >> 8) & 15) << 1), 13);
            default: begin v = 64'd0; e = 1'b1; end
        endcase
        if (xlen == 32) v[63:32] = 32'd0;
        return {e, v};
    endfunction

    task automatic sb_push(input bit wide, input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] tag);
        exp_t        e;
        logic [64:0] r;
        r     = ref_dec(ins, sel, wide ? 64 : 32);
        e.imm = r[63:0];
        e.err = r[64];
        e.tag = tag;
        if (wide) q64.push_back(e);
        else q32.push_back(e);
    endtask

    task automatic sb_pop(input bit wide, input logic [63:0] imm, input logic err, input logic [31:0] tag);
        exp_t e;
        int   n;
        n = wide ? q64.size() : q32.size();
        if (n == 0) begin
            check(wide ? "sb64_underflow" : "sb32_underflow", 64'(n), 64'd1);
        end else begin
            e = wide ? q64.pop_front() : q32.pop_front();
            check(wide ? "sb64_imm" : "sb32_imm", imm, e.imm);
            check(wide ? "sb64_err" : "sb32_err", 64'(err), 64'(e.err));
            check(wide ? "sb64_tag" : "sb32_tag", 64'(tag), 64'(e.tag));
        end
    endtask

    always @(negedge clk) begin
        if (rst || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (bus32.out_valid && bus32.out_ready)
                sb_pop(1'b0, 64'(bus32.out_imm), bus32.out_err, bus32.out_tag);
            if (bus64.out_valid && bus64.out_ready)
                sb_pop(1'b1, bus64.out_imm, bus64.out_err, bus64.out_tag);
            if (bus32.in_valid && bus32.in_ready)
                sb_push(1'b0, bus32.in_instr, bus32.in_sel, bus32.in_tag);
            if (bus64.in_valid && bus64.in_ready)
                sb_push(1'b1, bus64.in_instr, bus64.in_sel, bus64.in_tag);
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                         input logic [31:0] tag, input logic rdy);
        bus32.in_valid = v;   bus64.in_valid = v;
        bus32.in_instr = ins; bus64.in_instr = ins;
        bus32.in_sel   = sel; bus64.in_sel   = sel;
        bus32.in_tag   = tag; bus64.in_tag   = tag;
        bus32.out_ready = rdy; bus64.out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic f;
        drive(1'b0, 32'd0, 3'd0, 32'd0, 1'b1);
        tick();
        check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        check("rst_out_imm", bus64.out_imm, 64'd0);
        check("rst_out_tag", 64'(bus32.out_tag), 64'd0);
        check("rst_out_err", 64'(bus64.out_err), 64'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) begin
            drive(1'b1, t_ins[k], t_sel[k], 32'(k + 1), 1'b1);
            tick();
            check("b2b_valid", 64'(bus32.out_valid && bus64.out_valid), 64'd1);
            check("b2b_imm32", 64'(bus32.out_imm), {32'd0, t_exp[k][31:0]});
            check("b2b_imm64", bus64.out_imm, t_exp[k]);
            check("b2b_err", 64'({bus32.out_err, bus64.out_err}), {62'd0, t_err[k], t_err[k]});
            check("b2b_tag", 64'(bus64.out_tag), 64'(k + 1));
        end
        drive(1'b0, 32'd0, 3'd0, 32'd0, 1'b1);
        tick();

        drive(1'b1, $urandom, 3'd0, 32'd1, 1'b0);
        tick();
        drive(1'b1, $urandom, 3'd4, 32'd2, 1'b0);
        tick();
        drive(1'b1, $urandom, 3'd5, 32'd3, 1'b0);
        tick();
        check("bp_in_ready", 64'(bus32.in_ready), 64'd0);
        check("bp_hold_tag", 64'(bus32.out_tag), 64'd1);
        bus32.out_ready = 1'b1; bus64.out_ready = 1'b1;
        tick();
        check("bp_tag2", 64'(bus64.out_tag), 64'd2);
        check("bp_ready_back", 64'(bus64.in_ready), 64'd1);
        tick();
        check("bp_tag3", 64'(bus32.out_tag), 64'd3);
        drive(1'b0, 32'd0, 3'd0, 32'd0, 1'b1);
        tick();
        check("bp_empty", 64'(bus32.out_valid), 64'd0);

        drive(1'b1, $urandom, 3'd1, 32'd11, 1'b0);
        tick();
        drive(1'b1, $urandom, 3'd2, 32'd12, 1'b0);
        tick();
        check("fl_full", 64'(bus64.in_ready), 64'd0);
        drive(1'b1, $urandom, 3'd0, 32'd13, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_out_valid", 64'(bus32.out_valid || bus64.out_valid), 64'd0);
        check("fl_in_ready", 64'(bus32.in_ready && bus64.in_ready), 64'd1);
        drive(1'b0, 32'd0, 3'd0, 32'd0, 1'b1);
        tick();
        check("fl_dropped", 64'(bus64.out_valid), 64'd0);

        for (int i = 0; i < 400; i++) begin
            f = ($urandom_range(0, 31) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), $urandom,
                  f ? 1'b0 : ($urandom_range(0, 2) != 0));
            flush = f;
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 32'd0, 1'b1);
        for (int k = 0; k < 20 && (bus32.out_valid || bus64.out_valid); k++) tick();
        tick();
        check("drain_idle", 64'(bus32.out_valid || bus64.out_valid), 64'd0);
        check("drain_q32", 64'(q32.size()), 64'd0);
        check("drain_q64", 64'(q64.size()), 64'd0);

        drive(1'b1, 32'hFFF00093, 3'd0, 32'd5, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        bus32.in_valid = 1'b0; bus64.in_valid = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus32.out_valid || bus64.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus32.in_ready), 64'd1);
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h123450B7, 3'd2, 32'd7, 1'b1);
        tick();
        check("arst_first_valid", 64'(bus64.out_valid), 64'd1);
        check("arst_first_imm", bus64.out_imm, 64'h12345000);
        check("arst_first_tag", 64'(bus32.out_tag), 64'd7);
        drive(1'b0, 32'd0, 3'd0, 32'd0, 1'b1);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
